// File: rtl/serial_adder_4bits_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Purpose:
//    Shared definitions for the bit-serial adder lab block. This package holds
//    the controller state type and the default operand width, so the top and
//    any future variants agree on both.
//
// Contents:
//    DEFAULT_WIDTH  default operand width (4)
//    state_t        controller states {IDLE, RUN}
//    countWidth()   helper that sizes the bit-index counter for a given width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

   // Default operand width. The block is characterised at this width only.
   localparam int DEFAULT_WIDTH = 4;

   // IDLE waits for a start request. RUN walks the operand bits LSB first.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // The counter needs enough bits to hold WIDTH-1. It always keeps at least
   // one bit, so a degenerate WIDTH of 1 still gives a legal vector.
   function automatic int countWidth(input int width);
      if (width > 1) begin
         return $clog2(width);
      end
      return 1;
   endfunction

endpackage : serial_adder_pkg

// File: rtl/serial_adder_4bits_full_adder.sv
// ---------------------------------------------------------------------------
// full_adder
//
// Purpose:
//    Single-bit combinational full adder. The serial adder instantiates it
//    exactly once and reuses it for every bit position over successive
//    clocks.
//
// Ports:
//    a   input   1  operand bit A
//    b   input   1  operand bit B
//    ci  input   1  carry in
//    s   output  1  sum bit, a ^ b ^ ci
//    co  output  1  carry out, majority(a, b, ci)
// ---------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // The sum is the parity of the three inputs. The carry is set whenever at
   // least two of the three inputs are set.
   always_comb begin
      s  = a ^ b ^ ci;
      co = (a & b) | (a & ci) | (b & ci);
   end

endmodule : full_adder

// File: rtl/serial_adder_4bits.sv
// ---------------------------------------------------------------------------
// serial_adder_4bits
//
// Purpose:
//    Bit-serial adder computing {cout, c} = a + b + cin. It processes one bit
//    per clock, LSB first, through a single full-adder stage and a carry flop.
//    The operands are captured when start is accepted in IDLE. After WIDTH
//    RUN cycles the result is written to c/cout, and done pulses for one
//    cycle. c/cout then hold until the next completion or reset.
//
// Ports:
//    clk    input   1      rising-edge clock
//    rst    input   1      synchronous active-high reset, overrides all
//    start  input   1      request, only looked at while idle
//    a      input   WIDTH  addend A, captured on accept
//    b      input   WIDTH  addend B, captured on accept
//    cin    input   1      carry in, captured on accept
//    busy   output  1      high while a sum is in progress
//    done   output  1      one-cycle strobe, c/cout are new and valid
//    c      output  WIDTH  sum bits
//    cout   output  1      carry out
// ---------------------------------------------------------------------------
module serial_adder_4bits
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] c,
   output logic             cout
);

   localparam int CW = countWidth(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   state_t r_state;
   state_t w_stateNext;

   logic [WIDTH-1:0] r_aShift;
   logic [WIDTH-1:0] r_bShift;
   logic [WIDTH-1:0] r_sumShift;
   logic             r_carry;
   logic [CW-1:0]    r_count;

   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] r_c;
   logic             r_cout;

   logic             w_load;
   logic             w_step;
   logic             w_finish;
   logic             w_sumBit;
   logic             w_carryOut;
   logic [WIDTH-1:0] w_sumNext;

   // The single per-bit stage. It always looks at the current LSBs of the two
   // operand shift registers and at the carry left by the previous bit.
   full_adder uStage (
      .a  (r_aShift[0]),
      .b  (r_bShift[0]),
      .ci (r_carry),
      .s  (w_sumBit),
      .co (w_carryOut)
   );

   // The new sum bit enters at the MSB. After WIDTH steps the first bit
   // computed (bit 0) has reached position 0, so the word is in order.
   assign w_sumNext = {w_sumBit, r_sumShift[WIDTH-1:1]};

   // Controller state register. Reset returns to IDLE from anywhere, which
   // also silently aborts a sum in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic. A start in IDLE begins a sum. RUN stays put until the
   // last bit index has been processed. A start seen during RUN is dropped
   // here, because only the IDLE branch looks at it.
   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_stateNext = RUN;
            end
         end
         RUN: begin
            if (r_count == LAST_BIT) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Control strobes decoded from the state. load captures the operands,
   // step advances one bit, and finish marks the step that completes the
   // word. The step that finishes also clears busy and raises done.
   always_comb begin
      w_load   = 1'b0;
      w_step   = 1'b0;
      w_finish = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_load = start;
         end
         RUN: begin
            w_step   = 1'b1;
            w_finish = (r_count == LAST_BIT);
         end
         default: begin
            w_load = 1'b0;
         end
      endcase
   end

   // Datapath: operand and sum shift registers, the carry flop and the bit
   // counter. Loading clears the partial sum so stale bits from an earlier
   // word can never leak into the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aShift   <= '0;
         r_bShift   <= '0;
         r_sumShift <= '0;
         r_carry    <= 1'b0;
         r_count    <= '0;
      end else if (w_load) begin
         r_aShift   <= a;
         r_bShift   <= b;
         r_sumShift <= '0;
         r_carry    <= cin;
         r_count    <= '0;
      end else if (w_step) begin
         r_aShift   <= {1'b0, r_aShift[WIDTH-1:1]};
         r_bShift   <= {1'b0, r_bShift[WIDTH-1:1]};
         r_sumShift <= w_sumNext;
         r_carry    <= w_carryOut;
         r_count    <= w_finish ? '0 : r_count + CW'(1);
      end
   end

   // Output registers. c/cout are written only on the finishing step. They
   // therefore stay frozen for the whole RUN and hold their value afterwards.
   // done simply mirrors the finishing step one clock later. busy rises on
   // accept and falls on the finishing step, so it never overlaps done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
         r_c    <= '0;
         r_cout <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_load) begin
            r_busy <= 1'b1;
         end else if (w_finish) begin
            r_busy <= 1'b0;
         end
         if (w_finish) begin
            r_c    <= w_sumNext;
            r_cout <= w_carryOut;
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign c    = r_c;
   assign cout = r_cout;

endmodule : serial_adder_4bits

// File: tb/tb_serial_adder_4bits.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_4bits
//
// Purpose:
//    Self-checking bench for serial_adder_4bits. Expected results come from
//    plain integer addition of the operands. The expected timing comes from
//    the rule that done follows the accept edge by four clocks.
// ---------------------------------------------------------------------------
module tb_serial_adder_4bits;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] c;
   logic         cout;

   int checkCount;
   int passCount;

   // Last completed result according to the bench's own arithmetic. The
   // outputs must hold this value while a new sum is running.
   logic [W:0] prevResult;

   serial_adder_4bits #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .c     (c),
      .cout  (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then settle so that outputs are sampled and
   // inputs are driven well away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single point of comparison: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Issue one addition and follow it to its done strobe. When scramble is
   // set, the operand inputs change and start is pulsed at random while busy;
   // neither may disturb the captured sum. On return the bench sits in the
   // cycle where done is high.
   task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                input logic icin, input bit scramble);
      logic [W:0] expected;
      int         cycles;
      expected = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, icin};
      a     = ia;
      b     = ib;
      cin   = icin;
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("busyAfterAccept", 32'(busy), 32'd1);
      cycles = 0;
      while (!done && cycles < 8) begin
         checkOutput("holdDuringRun", 32'({cout, c}), 32'(prevResult));
         if (scramble) begin
            a     = W'($urandom);
            b     = W'($urandom);
            cin   = 1'($urandom);
            start = 1'($urandom);
         end
         tick();
         cycles++;
      end
      start = 1'b0;
      checkOutput("latency", 32'(cycles), 32'd4);
      checkOutput("doneHigh", 32'(done), 32'd1);
      checkOutput("busyLowOnDone", 32'(busy), 32'd0);
      checkOutput("sum", 32'(c), 32'(expected[W-1:0]));
      checkOutput("carryOut", 32'(cout), 32'(expected[W]));
      prevResult = expected;
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           gap;

      checkCount = 0;
      passCount  = 0;
      prevResult = '0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;

      // Reset for two cycles, then idle with start low.
      tick();
      tick();
      checkOutput("resetC", 32'(c), 32'd0);
      checkOutput("resetCout", 32'(cout), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      checkOutput("resetBusy", 32'(busy), 32'd0);
      rst = 1'b0;
      a   = 4'b1010;
      b   = 4'b0101;
      tick();
      tick();
      checkOutput("idleBusy", 32'(busy), 32'd0);
      checkOutput("idleDone", 32'(done), 32'd0);
      checkOutput("idleResult", 32'({cout, c}), 32'd0);

      // Directed sums and carry chains.
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b0001, 4'b0100, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b1100, 4'b0011, 1'b0, 1'b0);
      tick();
      checkOutput("doneOneCycle", 32'(done), 32'd0);
      checkOutput("holdAfterDone", 32'({cout, c}), 32'(prevResult));
      applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b0);
      tick();
      applyStimulus(4'b1101, 4'b0011, 1'b1, 1'b0);

      // Back-to-back: start again in the done cycle, with scrambled inputs
      // and stray start pulses during the run.
      applyStimulus(4'b0110, 4'b0111, 1'b0, 1'b1);
      applyStimulus(4'b1001, 4'b1011, 1'b1, 1'b1);
      tick();

      // Reset two cycles after accept: the run aborts with no done.
      a     = 4'b0111;
      b     = 4'b0111;
      cin   = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      prevResult = '0;
      checkOutput("abortBusy", 32'(busy), 32'd0);
      checkOutput("abortDone", 32'(done), 32'd0);
      checkOutput("abortResult", 32'({cout, c}), 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("abortNoDone", 32'(done), 32'd0);
      end
      applyStimulus(4'b1011, 4'b0110, 1'b1, 1'b0);

      // Randomised operands with random idle gaps between requests.
      for (int i = 0; i < 1000; i++) begin
         ra  = W'($urandom);
         rb  = W'($urandom);
         rc  = 1'($urandom);
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            tick();
         end
         applyStimulus(ra, rb, rc, 1'($urandom));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_serial_adder_4bits
